// File: rtl/bus_cycle_gen.sv
// T1..T4 multiplexed address/data bus cycle generator with registered Moore outputs.
// Define BUS_CYCLE_WAIT_EN to enable READY-driven wait states (TW) and bus timeout.
module bus_cycle_gen #(
    parameter logic        IOM      = 1'b0,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [19:0] addr,
    input  logic [15:0] wdata,
    input  logic        READY,
    input  logic [15:0] ad_in,
    output logic        ALE,
    output logic        rdb,
    output logic        wrb,
    output logic        M_IO,
    output logic [19:0] ad_out,
    output logic        ad_oe,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

`ifdef BUS_CYCLE_WAIT_EN
    typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;
`else
    typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;
`endif

    state_t      state_q, state_d;
    logic        start;
    logic        wr_q, wr_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ale_q, ale_d;
    logic        rdb_q, rdb_d;
    logic        wrb_q, wrb_d;
    logic        oe_q, oe_d;
    logic [19:0] ad_q, ad_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

`ifdef BUS_CYCLE_WAIT_EN
    logic [7:0]  wcnt_q, wcnt_d;
    logic        err_q, err_d;
`else
    logic        unused_cfg;
    assign unused_cfg = READY ^ (MAX_WAIT == 0);
`endif

    assign start   = (state_q == IDLE) && req;
    assign wr_d    = start ? wr    : wr_q;
    assign addr_d  = start ? addr  : addr_q;
    assign wdata_d = start ? wdata : wdata_q;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
`ifdef BUS_CYCLE_WAIT_EN
        wcnt_d  = wcnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = T1;
`ifdef BUS_CYCLE_WAIT_EN
                    wcnt_d  = 8'd0;
                    err_d   = 1'b0;
`endif
                end
            end
            T1: state_d = T2;
            T2: state_d = T3;
`ifdef BUS_CYCLE_WAIT_EN
            T3, TW: begin
                if (READY) begin
                    state_d = T4;
                    if (!wr_q) rdata_d = ad_in;
                end else if (wcnt_q == 8'(MAX_WAIT)) begin
                    // Timed-out reads return all-ones so software sees a float.
                    state_d = T4;
                    err_d   = 1'b1;
                    if (!wr_q) rdata_d = 16'hFFFF;
                end else begin
                    state_d = TW;
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
`else
            T3: begin
                state_d = T4;
                if (!wr_q) rdata_d = ad_in;
            end
`endif
            T4: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registers match state_q.
    always_comb begin
        ale_d  = 1'b0;
        rdb_d  = 1'b1;
        wrb_d  = 1'b1;
        oe_d   = 1'b0;
        ad_d   = '0;
        busy_d = 1'b1;
        done_d = 1'b0;
        unique case (state_d)
            IDLE: busy_d = 1'b0;
            T1: begin
                ale_d = 1'b1;
                ad_d  = addr_d;
                oe_d  = 1'b1;
            end
            T4: done_d = 1'b1;
            default: begin
                if (wr_d) begin
                    wrb_d = 1'b0;
                    ad_d  = {4'b0, wdata_d};
                    oe_d  = 1'b1;
                end else begin
                    rdb_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ale_q   <= 1'b0;
            rdb_q   <= 1'b1;
            wrb_q   <= 1'b1;
            oe_q    <= 1'b0;
            ad_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ale_q   <= ale_d;
            rdb_q   <= rdb_d;
            wrb_q   <= wrb_d;
            oe_q    <= oe_d;
            ad_q    <= ad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef BUS_CYCLE_WAIT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign M_IO   = IOM;
    assign ALE    = ale_q;
    assign rdb    = rdb_q;
    assign wrb    = wrb_q;
    assign ad_oe  = oe_q;
    assign ad_out = ad_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_bus_cycle_gen.sv
// Directed bench for bus_cycle_gen: scoreboard of expected completions
// checked on done, plus per-cycle strobe/bus checks.
module tb_bus_cycle_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic        wr    = 1'b0;
    logic        READY = 1'b1;
    logic [19:0] addr  = '0;
    logic [15:0] wdata = '0;
    logic [15:0] ad_in = '0;
    logic        ALE, rdb, wrb, M_IO, ad_oe, busy, done, err;
    logic [19:0] ad_out;
    logic [15:0] rdata;
    logic        done_s, err_s;
    logic [15:0] rdata_s;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          lat;
        logic        err;
        logic        rd;
        logic [15:0] rdata;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    bus_cycle_gen dut (
        .clock(clock), .reset(reset), .req(req), .wr(wr),
        .addr(addr), .wdata(wdata), .READY(READY), .ad_in(ad_in),
        .ALE(ALE), .rdb(rdb), .wrb(wrb), .M_IO(M_IO),
        .ad_out(ad_out), .ad_oe(ad_oe), .rdata(rdata),
        .busy(busy), .done(done), .err(err)
    );

`ifdef BUS_CYCLE_WAIT_EN
    logic        sel   = 1'b0;
    logic        req_t = 1'b0;
    logic        ALE_t, rdb_t, wrb_t, M_IO_t, ad_oe_t, busy_t, done_t, err_t;
    logic [19:0] ad_out_t;
    logic [15:0] rdata_t;

    bus_cycle_gen #(.MAX_WAIT(2)) dut_t (
        .clock(clock), .reset(reset), .req(req_t), .wr(wr),
        .addr(addr), .wdata(wdata), .READY(READY), .ad_in(ad_in),
        .ALE(ALE_t), .rdb(rdb_t), .wrb(wrb_t), .M_IO(M_IO_t),
        .ad_out(ad_out_t), .ad_oe(ad_oe_t), .rdata(rdata_t),
        .busy(busy_t), .done(done_t), .err(err_t)
    );

    assign done_s  = sel ? done_t  : done;
    assign err_s   = sel ? err_t   : err;
    assign rdata_s = sel ? rdata_t : rdata;
`else
    assign done_s  = done;
    assign err_s   = err;
    assign rdata_s = rdata;
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe exclusivity and ALE/strobe overlap on every cycle.
    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            assert (!(!rdb && !wrb) && !(ALE && (!rdb || !wrb))) else begin
                failures++;
                $error("FAIL strobe_excl observed=ALE%b rdb%b wrb%b expected=exclusive",
                       ALE, rdb, wrb);
            end
        end
    end

    // Leaves the bench at the negedge of cycle 1 (T1).
    task automatic start(input logic w, input logic [19:0] a,
                         input logic [15:0] d);
        @(negedge clock);
        req = 1'b1; wr = w; addr = a; wdata = d;
        @(negedge clock);
        req = 1'b0;
    endtask

    task automatic wait_done(input int cyc_now);
        exp_t e;
        int   n = cyc_now;
        while (done_s !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        e = sb.pop_front();
        chk("done_seen", done_s, 1);
        chk("latency", n, e.lat);
        chk("err", err_s, e.err);
        if (e.rd) chk("rdata", rdata_s, e.rdata);
    endtask

    initial begin
        int nlow;

        // Reset values
        @(negedge clock);
        chk("rst_ale", ALE, 0);
        chk("rst_rdb", rdb, 1);
        chk("rst_wrb", wrb, 1);
        chk("rst_oe", ad_oe, 0);
        chk("rst_ad", ad_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("m_io", M_IO, 0);
        reset = 1'b0;

        // Write cycle
        READY = 1'b1;
        sb.push_back('{4, 1'b0, 1'b0, 16'h0});
        start(1'b1, 20'hA5A5A, 16'h1234);
        chk("w_t1_ale", ALE, 1);
        chk("w_t1_ad", ad_out, 20'hA5A5A);
        chk("w_t1_oe", ad_oe, 1);
        chk("w_t1_wrb", wrb, 1);
        chk("w_t1_busy", busy, 1);
        addr = 20'h0; wdata = 16'hFFFF;
        @(negedge clock);
        chk("w_t2_wrb", wrb, 0);
        chk("w_t2_ale", ALE, 0);
        chk("w_t2_ad", ad_out, 20'h01234);
        chk("w_t2_oe", ad_oe, 1);
        @(negedge clock);
        chk("w_t3_wrb", wrb, 0);
        chk("w_t3_ad", ad_out, 20'h01234);
        @(negedge clock);
        chk("w_t4_wrb", wrb, 1);
        chk("w_t4_oe", ad_oe, 0);
        wait_done(4);
        @(negedge clock);
        chk("w_idle_done", done, 0);
        chk("w_idle_busy", busy, 0);

        // Read cycle
        ad_in = 16'hBEEF;
        sb.push_back('{4, 1'b0, 1'b1, 16'hBEEF});
        start(1'b0, 20'h00010, 16'h0);
        chk("r_t1_ad", ad_out, 20'h00010);
        @(negedge clock);
        chk("r_t2_rdb", rdb, 0);
        chk("r_t2_oe", ad_oe, 0);
        @(negedge clock);
        chk("r_t3_rdb", rdb, 0);
        @(negedge clock);
        chk("r_t4_rdb", rdb, 1);
        wait_done(4);
        ad_in = 16'h0000;

        // Back-to-back: req held high through the whole cycle
        sb.push_back('{4, 1'b0, 1'b0, 16'h0});
        @(negedge clock);
        req = 1'b1; wr = 1'b1; addr = 20'h12345; wdata = 16'h5555;
        @(negedge clock);
        chk("b2b_t1", ALE, 1);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        wait_done(4);
        @(negedge clock);
        chk("b2b_gap_busy", busy, 0);
        chk("b2b_gap_ale", ALE, 0);
        @(negedge clock);
        req = 1'b0;
        chk("b2b_2nd_t1", ALE, 1);
        chk("b2b_2nd_ad", ad_out, 20'h12345);
        sb.push_back('{4, 1'b0, 1'b0, 16'h0});
        wait_done(1);
        chk("rdata_hold", rdata, 16'hBEEF);

        // req pulsed during T2 is ignored
        sb.push_back('{4, 1'b0, 1'b0, 16'h0});
        start(1'b1, 20'h00ABC, 16'h00FF);
        @(negedge clock);
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        wait_done(4);
        @(negedge clock);
        chk("ign_busy5", busy, 0);
        @(negedge clock);
        chk("ign_busy6", busy, 0);
        chk("ign_ale6", ALE, 0);

        // Asynchronous reset in T3 of a write
        start(1'b1, 20'h33333, 16'hAAAA);
        @(negedge clock);
        @(negedge clock);
        chk("ar_pre_wrb", wrb, 0);
        #2 reset = 1'b1;
        #1;
        chk("ar_wrb", wrb, 1);
        chk("ar_ale", ALE, 0);
        chk("ar_oe", ad_oe, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("ar_nodone", done, 0);
        ad_in = 16'h0F0F;
        sb.push_back('{4, 1'b0, 1'b1, 16'h0F0F});
        start(1'b0, 20'h44444, 16'h0);
        chk("ar_t1_ale", ALE, 1);
        chk("ar_t1_ad", ad_out, 20'h44444);
        wait_done(1);

`ifdef BUS_CYCLE_WAIT_EN
        // Three wait states then READY
        ad_in = 16'hCAFE;
        READY = 1'b0;
        nlow = 0;
        sb.push_back('{7, 1'b0, 1'b1, 16'hCAFE});
        start(1'b0, 20'h00020, 16'h0);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clock);
            if (rdb === 1'b0) nlow++;
            if (c == 6) READY = 1'b1;
        end
        wait_done(6);
        chk("ws_rdb_low", nlow, 5);

        // Timeout on the MAX_WAIT=2 instance
        READY = 1'b0;
        sel   = 1'b1;
        sb.push_back('{6, 1'b1, 1'b1, 16'hFFFF});
        @(negedge clock);
        req_t = 1'b1; wr = 1'b0; addr = 20'h00030;
        @(negedge clock);
        req_t = 1'b0;
        wait_done(1);
        @(negedge clock);
        chk("to_err_hold", err_t, 1);
        READY = 1'b1;
        ad_in = 16'h1357;
        sb.push_back('{4, 1'b0, 1'b1, 16'h1357});
        @(negedge clock);
        req_t = 1'b1;
        @(negedge clock);
        req_t = 1'b0;
        chk("to_err_clr", err_t, 0);
        wait_done(1);
        sel = 1'b0;
`else
        // READY ignored without wait-state support
        READY = 1'b0;
        ad_in = 16'h7777;
        sb.push_back('{4, 1'b0, 1'b1, 16'h7777});
        start(1'b0, 20'h00040, 16'h0);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        chk("nw_t4_rdb", rdb, 1);
        wait_done(4);
        chk("nw_err", err, 0);
        READY = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
